// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx round-robin arbiter: FSM state
// encoding, default sizes and the owner-index width helper.
package uart_tx_arbiter_pkg;

   // Arbiter FSM states; encoding is fixed so debug probes decode stably.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_BSY  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_HOLD      = 3'd5
   } state_t;

   localparam int N_SRC_DEF      = 4;
   localparam int DATA_WIDTH_DEF = 8;

   // Width of an index into N requesters; never narrower than one bit.
   function automatic int owner_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int OWNER_W = owner_width(N_SRC_DEF);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the arbiter and uart_tx.
//
// Handshake: req[i] acts as valid for source i. The byte in
// req_data[i*DATA_WIDTH +: DATA_WIDTH] and req_last[i] must stay stable while
// req[i] is high. The arbiter answers with a single-cycle ack[i]; the byte is
// taken at the clock edge that ends the ack cycle. A source with no further
// byte drops req[i] during that ack cycle. Toward uart_tx, tx_start is a
// single-cycle pulse issued only while tx_ready is high, with tx_data valid
// in the same cycle.
interface uart_tx_arbiter_if
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_SRC      = N_SRC_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

   localparam int OWN_W = owner_width(N_SRC);

   logic [N_SRC-1:0]            req;
   logic [N_SRC-1:0]            req_last;
   logic [N_SRC*DATA_WIDTH-1:0] req_data;
   logic [N_SRC-1:0]            ack;
   logic                        tx_start;
   logic [DATA_WIDTH-1:0]       tx_data;
   logic                        tx_ready;
   logic                        busy;
   logic [OWN_W-1:0]            owner;
   state_t                      dbg_state;

   // Arbiter side.
   modport master (
      input  req, req_last, req_data, tx_ready,
      output ack, tx_start, tx_data, busy, owner, dbg_state
   );

   // Producers plus uart_tx side.
   modport slave (
      output req, req_last, req_data, tx_ready,
      input  ack, tx_start, tx_data, busy, owner, dbg_state
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority finder. The search starts at the
// requester just after rr_ptr and wraps, so the last packet owner gets the
// lowest priority.
module uart_tx_arbiter_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF,
   parameter int OWN_W = OWNER_W
) (
   input  logic [N_SRC-1:0] req,
   input  logic [OWN_W-1:0] rr_ptr,
   output logic [OWN_W-1:0] grant,
   output logic             valid
);

   int idx;

   // Walk the requesters from rr_ptr+1 onward and take the first one found.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = (int'(rr_ptr) + k) % N_SRC;
         if (!valid && req[idx]) begin
            valid = 1'b1;
            grant = idx[OWN_W-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_SRC byte producers. Ownership is granted
// round-robin and held for a whole packet, so multi-byte messages are never
// interleaved on the line. Completion of each byte is tracked through the
// uart_tx ready signal.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_SRC      = N_SRC_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_arbiter_if.master  bus
);

   localparam int OWN_W = owner_width(N_SRC);
   localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

   state_t                state_q;
   logic [OWN_W-1:0]      owner_q;
   logic [OWN_W-1:0]      rr_ptr_q;
   logic [N_SRC-1:0]      ack_q;
   logic                  tx_start_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic                  last_q;

   logic [OWN_W-1:0]      pick_idx;
   logic                  pick_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_last;
   logic                  owner_req;

   uart_tx_arbiter_rr_pick #(
      .N_SRC (N_SRC),
      .OWN_W (OWN_W)
   ) u_rr_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr_q),
      .grant  (pick_idx),
      .valid  (pick_valid)
   );

   // Byte, end-of-packet flag and request line of the current owner.
   always_comb begin
      sel_data  = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      sel_last  = bus.req_last[owner_q];
      owner_req = bus.req[owner_q];
   end

   // Packet-ownership FSM. ack is raised on entry to LOAD so it is high for
   // exactly the LOAD cycle; tx_start is raised on entry to START so it is
   // high for exactly the START cycle, one cycle after ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= OWN_W'(N_SRC - 1);
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         last_q     <= 1'b0;
      end else begin
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A reset may leave uart_tx mid-frame; only arbitrate once it is idle.
               if (pick_valid && bus.tx_ready) begin
                  owner_q <= pick_idx;
                  ack_q   <= ONE << pick_idx;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tx_data_q  <= sel_data;
               last_q     <= sel_last;
               tx_start_q <= 1'b1;
               state_q    <= ST_START;
            end
            ST_START: begin
               state_q <= ST_WAIT_BSY;
            end
            ST_WAIT_BSY: begin
               if (!bus.tx_ready) begin
                  state_q <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.tx_ready) begin
                  if (last_q) begin
                     rr_ptr_q <= owner_q;
                     state_q  <= ST_IDLE;
                  end else if (owner_req) begin
                     ack_q   <= ONE << owner_q;
                     state_q <= ST_LOAD;
                  end else begin
                     state_q <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // The owner keeps the line until its packet ends; no timeout.
               if (owner_req) begin
                  ack_q   <= ONE << owner_q;
                  state_q <= ST_LOAD;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ack       = ack_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.owner     = owner_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx (16 clocks per bit)
// and a serial-line receiver that checks every frame against exp_q.
module tb_uart_tx_arbiter;
   import uart_tx_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int CPB = 16;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req      = '0;
   logic [N-1:0]    req_last = '0;
   logic [N*DW-1:0] req_data = '0;

   // uart_tx model state (not touched by the arbiter reset)
   logic       u_ready = 1'b1;
   logic       u_busy  = 1'b0;
   logic       line    = 1'b1;
   logic [9:0] u_sh    = '1;
   int         u_bit   = 0;
   int         u_cyc   = 0;

   int         total   = 0;
   int         bad     = 0;
   int         rx_cnt  = 0;
   logic [DW-1:0] exp_q[$];
   logic       prev_start = 1'b0;

   uart_tx_arbiter_if #(.N_SRC(N), .DATA_WIDTH(DW)) bus ();

   assign bus.req      = req;
   assign bus.req_last = req_last;
   assign bus.req_data = req_data;
   assign bus.tx_ready = u_ready;

   uart_tx_arbiter #(.N_SRC(N), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // uart_tx model: samples start while ready, sends start/8 data/stop bits.
   always @(posedge clk) begin
      if (u_busy) begin
         if (u_cyc == CPB - 1) begin
            u_cyc <= 0;
            if (u_bit == 9) begin
               u_busy  <= 1'b0;
               u_ready <= 1'b1;
               line    <= 1'b1;
            end else begin
               u_bit <= u_bit + 1;
               line  <= u_sh[u_bit + 1];
            end
         end else begin
            u_cyc <= u_cyc + 1;
         end
      end else if (bus.tx_start && u_ready) begin
         u_sh    <= {1'b1, bus.tx_data, 1'b0};
         line    <= 1'b0;
         u_bit   <= 0;
         u_cyc   <= 0;
         u_busy  <= 1'b1;
         u_ready <= 1'b0;
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Serial receiver: mid-bit sampling, compares each byte with exp_q.
   initial begin : rx
      logic [DW-1:0] b;
      logic [DW-1:0] e;
      forever begin
         do @(negedge clk); while (line !== 1'b0);
         repeat (CPB/2 - 1) @(negedge clk);
         check("rx start bit", line, 1'b0);
         for (int i = 0; i < DW; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = line;
         end
         repeat (CPB) @(negedge clk);
         check("rx stop bit", line, 1'b1);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx byte: got %0h expected none", b);
         end else begin
            e = exp_q.pop_front();
            check("rx byte", b, e);
         end
         rx_cnt++;
      end
   end

   // Always-on protocol checks.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.ack != '0) check("ack onehot", 32'($onehot0(bus.ack)), 1);
         if (bus.tx_start) begin
            check("tx_start single cycle", prev_start, 1'b0);
            check("tx_start while ready", u_ready, 1'b1);
            check("tx_start in START", bus.dbg_state == ST_START, 1'b1);
         end
      end
      prev_start = bus.tx_start;
   end

   // ---------------- driver tasks ----------------
   task automatic set_src(input int i, input logic [DW-1:0] d, input logic l, input logic r);
      req_data[i*DW +: DW] = d;
      req_last[i] = l;
      req[i] = r;
   endtask

   task automatic wait_ack(input string name, output logic [N-1:0] a);
      int n;
      a = '0;
      n = 0;
      while (a == '0 && n < 600) begin
         @(negedge clk);
         n++;
         a = bus.ack;
      end
      if (a == '0) fail({name, " ack wait"});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((bus.busy || exp_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, " rx pending"}, exp_q.size(), 0);
      check({name, " busy"}, bus.busy, 1'b0);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, " ack"}, bus.ack, '0);
      check({name, " tx_start"}, bus.tx_start, 1'b0);
      check({name, " tx_data"}, bus.tx_data, '0);
      check({name, " busy"}, bus.busy, 1'b0);
      check({name, " owner"}, bus.owner, '0);
      check({name, " state"}, bus.dbg_state, ST_IDLE);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         do_rst;
      logic [N-1:0] mask;
      int           per_src;
      int           n;
      int           exp_own[8];
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input int v);
      int left[N];
      int k;
      int budget;
      logic [N-1:0] a;
      if (vecs[v].do_rst) begin
         @(posedge clk); #1 reset = 1'b1;
         @(posedge clk); #1 reset = 1'b0;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         left[i] = vecs[v].mask[i] ? vecs[v].per_src : 0;
         set_src(i, 8'(8'h10 + i), 1'b1, vecs[v].mask[i]);
      end
      for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(8'(8'h10 + vecs[v].exp_own[j]));
      k = 0;
      budget = 0;
      while (k < vecs[v].n && budget < 300 * vecs[v].n) begin
         @(negedge clk);
         budget++;
         a = bus.ack;
         if (a != '0) begin
            check($sformatf("vec%0d ack #%0d", v, k), a, 32'(1) << vecs[v].exp_own[k]);
            check($sformatf("vec%0d owner #%0d", v, k), bus.owner, vecs[v].exp_own[k]);
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
               if (a[i]) begin
                  left[i]--;
                  if (left[i] <= 0) req[i] = 1'b0;
               end
            end
            @(negedge clk);
            budget++;
            check($sformatf("vec%0d tx_start #%0d", v, k), bus.tx_start, 1'b1);
            check($sformatf("vec%0d tx_data #%0d", v, k), bus.tx_data, 8'h10 + vecs[v].exp_own[k]);
            k++;
         end
      end
      if (k < vecs[v].n) fail($sformatf("vec%0d grants", v));
      req = '0;
      drain($sformatf("vec%0d", v));
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [N-1:0] a;
      int n;
      int cnt_a;
      int cnt_b;
      logic [DW-1:0] bytes1[3];
      int idx1;
      int rx_base;
      logic ack2_seen;

      vecs[0] = '{do_rst: 1'b1, mask: 4'b1111, per_src: 2, n: 8, exp_own: '{0, 1, 2, 3, 0, 1, 2, 3}};
      vecs[1] = '{do_rst: 1'b0, mask: 4'b0110, per_src: 1, n: 2, exp_own: '{1, 2, 0, 0, 0, 0, 0, 0}};
      vecs[2] = '{do_rst: 1'b0, mask: 4'b1001, per_src: 1, n: 2, exp_own: '{3, 0, 0, 0, 0, 0, 0, 0}};
      vecs[3] = '{do_rst: 1'b0, mask: 4'b1010, per_src: 1, n: 2, exp_own: '{1, 3, 0, 0, 0, 0, 0, 0}};
      vecs[4] = '{do_rst: 1'b0, mask: 4'b0101, per_src: 2, n: 4, exp_own: '{0, 2, 0, 2, 0, 0, 0, 0}};

      // Test 1: reset values, single byte, latency and frame.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      set_src(0, 8'hA5, 1'b1, 1'b1);
      exp_q.push_back(8'hA5);
      @(negedge clk);
      check("t1 no ack while arbitrating", bus.ack, '0);
      check("t1 state idle", bus.dbg_state, ST_IDLE);
      @(negedge clk);
      check("t1 ack", bus.ack, 4'b0001);
      check("t1 busy", bus.busy, 1'b1);
      @(posedge clk); #1 req[0] = 1'b0;
      @(negedge clk);
      check("t1 tx_start", bus.tx_start, 1'b1);
      check("t1 tx_data", bus.tx_data, 8'hA5);
      check("t1 ack gone", bus.ack, '0);
      @(negedge clk);
      check("t1 state wait_bsy", bus.dbg_state, ST_WAIT_BSY);
      check("t1 tx_start gone", bus.tx_start, 1'b0);
      n = 0;
      while (bus.busy && n < 400) begin @(negedge clk); n++; end
      check("t1 busy cleared", bus.busy, 1'b0);
      check("t1 ready when idle", u_ready, 1'b1);
      check("t1 tx_data held", bus.tx_data, 8'hA5);
      drain("t1");

      // Tests 2 and table: round-robin ordering.
      for (int v = 0; v < 5; v++) run_vec(v);

      // Test 3: packet from src1 not interleaved with src2.
      bytes1 = '{8'h01, 8'h02, 8'h03};
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h03); exp_q.push_back(8'hFF);
      rx_base = rx_cnt;
      idx1 = 0;
      ack2_seen = 1'b0;
      @(posedge clk); #1 set_src(1, 8'h01, 1'b0, 1'b1);
      n = 0;
      while (!ack2_seen && n < 3000) begin
         @(negedge clk);
         n++;
         a = bus.ack;
         if (a[2]) begin
            ack2_seen = 1'b1;
            check("t3 src1 bytes before src2", idx1, 3);
            check("t3 frames done before ack2", rx_cnt - rx_base, 3);
            @(posedge clk); #1 req[2] = 1'b0;
         end else if (a[1]) begin
            idx1++;
            @(posedge clk); #1;
            if (idx1 == 1) set_src(2, 8'hFF, 1'b1, 1'b1);
            if (idx1 < 3) set_src(1, bytes1[idx1], idx1 == 2, 1'b1);
            else req[1] = 1'b0;
         end
      end
      if (!ack2_seen) fail("t3 src2 ack");
      drain("t3");

      // Test 4: HOLD keeps the line for the owner.
      exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h33);
      @(posedge clk); #1 set_src(0, 8'h55, 1'b0, 1'b1);
      wait_ack("t4 first", a);
      check("t4 first ack", a, 4'b0001);
      @(posedge clk); #1;
      req[0] = 1'b0;
      set_src(3, 8'h33, 1'b1, 1'b1);
      n = 0;
      while (bus.dbg_state != ST_HOLD && n < 400) begin @(negedge clk); n++; end
      check("t4 reached hold", bus.dbg_state, ST_HOLD);
      cnt_a = 0;
      cnt_b = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.tx_start) cnt_a++;
         if (bus.ack != '0) cnt_b++;
      end
      check("t4 no tx_start in hold", cnt_a, 0);
      check("t4 no ack in hold", cnt_b, 0);
      check("t4 still hold", bus.dbg_state, ST_HOLD);
      check("t4 owner kept", bus.owner, 0);
      check("t4 busy in hold", bus.busy, 1'b1);
      @(posedge clk); #1 set_src(0, 8'hAA, 1'b1, 1'b1);
      wait_ack("t4 second", a);
      check("t4 owner resumes", a, 4'b0001);
      @(posedge clk); #1 req[0] = 1'b0;
      wait_ack("t4 third", a);
      check("t4 src3 after packet", a, 4'b1000);
      @(posedge clk); #1 req[3] = 1'b0;
      drain("t4");

      // Test 5: reset during the data bits of a frame.
      exp_q.push_back(8'h3C);
      @(posedge clk); #1 set_src(1, 8'h3C, 1'b1, 1'b1);
      wait_ack("t5 first", a);
      check("t5 first ack", a, 4'b0010);
      @(posedge clk); #1 req[1] = 1'b0;
      n = 0;
      while (u_ready && n < 50) begin @(negedge clk); n++; end
      repeat (CPB * 4) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_vals("t5 async reset");
      @(posedge clk); #1 reset = 1'b0;
      exp_q.push_back(8'hC3);
      set_src(2, 8'hC3, 1'b1, 1'b1);
      cnt_a = 0;
      cnt_b = 0;
      n = 0;
      while (!u_ready && n < 300) begin
         @(negedge clk);
         n++;
         if (bus.ack != '0) cnt_a++;
         if (bus.dbg_state != ST_IDLE) cnt_b++;
      end
      check("t5 no ack while uart busy", cnt_a, 0);
      check("t5 idle while uart busy", cnt_b, 0);
      wait_ack("t5 second", a);
      check("t5 second ack", a, 4'b0100);
      check("t5 ready at ack", u_ready, 1'b1);
      @(posedge clk); #1 req[2] = 1'b0;
      drain("t5");

      check("final queue empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog: the run must end on its own.
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
